// File: rtl/dpmem_pkg.sv
// dpmem_pkg: shared FSM type, default geometry and byte-lane mask helper for dpmem_bw_ctrl.
package dpmem_pkg;

    typedef enum logic {CLEAR, RUN} state_e;

    localparam int DEF_DATA_W = 32;
    localparam int DEF_ADDR_W = 11;
    localparam int DEF_DEPTH  = 2048;
    localparam int MAX_NB     = 32;
    localparam int MAX_W      = 8 * MAX_NB;

    // Active-low byte enables in, active-high per-bit write mask out; callers truncate to DATA_W
    function automatic logic [MAX_W-1:0] lane_mask(input logic [MAX_NB-1:0] bwen_n);
        logic [MAX_W-1:0] m;
        m = '0;
        for (int b = 0; b < MAX_NB; b++) m[8*b +: 8] = {8{~bwen_n[b]}};
        return m;
    endfunction

endpackage

// File: rtl/dpmem_bw_ctrl_if.sv
// dpmem_bw_ctrl_if: both memory ports' request and read-return signals.
interface dpmem_bw_ctrl_if #(
    parameter int DATA_W = dpmem_pkg::DEF_DATA_W,
    parameter int ADDR_W = dpmem_pkg::DEF_ADDR_W
);
    localparam int NB = DATA_W / 8;

    logic              CEN0, WEN0, QV0;
    logic [NB-1:0]     BWEN0;
    logic [ADDR_W-1:0] A0;
    logic [DATA_W-1:0] D0, Q0;
    logic              CEN1, WEN1, QV1;
    logic [NB-1:0]     BWEN1;
    logic [ADDR_W-1:0] A1;
    logic [DATA_W-1:0] D1, Q1;

    modport master (
        output CEN0, WEN0, BWEN0, A0, D0, CEN1, WEN1, BWEN1, A1, D1,
        input  Q0, QV0, Q1, QV1
    );

    modport slave (
        input  CEN0, WEN0, BWEN0, A0, D0, CEN1, WEN1, BWEN1, A1, D1,
        output Q0, QV0, Q1, QV1
    );

endinterface

// File: rtl/dpmem_port_rd.sv
// dpmem_port_rd: registered read data/valid for one port; DPMEM_OUT_REG_EN adds a second stage.
module dpmem_port_rd #(
    parameter int DATA_W = 32
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              rd_en_i,
    input  logic [DATA_W-1:0] rd_data_i,
    output logic [DATA_W-1:0] q_o,
    output logic              qv_o
);

    logic [DATA_W-1:0] q1_q;
    logic              qv1_q;

    always_ff @(posedge clk) begin
        if (rst) begin
            q1_q  <= '0;
            qv1_q <= 1'b0;
        end else begin
            qv1_q <= rd_en_i;
            if (rd_en_i) q1_q <= rd_data_i;
        end
    end

`ifdef DPMEM_OUT_REG_EN
    logic [DATA_W-1:0] q2_q;
    logic              qv2_q;

    always_ff @(posedge clk) begin
        if (rst) begin
            q2_q  <= '0;
            qv2_q <= 1'b0;
        end else begin
            qv2_q <= qv1_q;
            if (qv1_q) q2_q <= q1_q;
        end
    end

    assign q_o  = q2_q;
    assign qv_o = qv2_q;
`else
    assign q_o  = q1_q;
    assign qv_o = qv1_q;
`endif

endmodule

// File: rtl/dpmem_bw_ctrl.sv
// dpmem_bw_ctrl: true dual-port byte-masked RAM with post-reset clear sweep and sticky collision flag.
// Define DPMEM_OUT_REG_EN for a second output register stage (read latency 2).
module dpmem_bw_ctrl
    import dpmem_pkg::*;
#(
    parameter int DATA_W = DEF_DATA_W,
    parameter int ADDR_W = DEF_ADDR_W,
    parameter int DEPTH  = DEF_DEPTH
) (
    input  logic              CLK,
    input  logic              RESET,
    dpmem_bw_ctrl_if.slave    bus,
    output logic              READY,
    output logic              COLL,
    input  logic              COLL_CLR
);

    localparam logic [ADDR_W:0]   DEPTH_L = (ADDR_W+1)'(DEPTH);
    localparam logic [ADDR_W-1:0] LAST    = ADDR_W'(DEPTH-1);

    state_e            state_q, state_d;
    logic [ADDR_W-1:0] cnt_q, cnt_d;
    logic              coll_q, coll_d;
    logic [DATA_W-1:0] mem [DEPTH];

    logic              clr_we, act, in0, in1, rd0, rd1, wr0, wr1, same;
    logic [DATA_W-1:0] m0, m1, rdata0, rdata1;

    always_comb begin
        clr_we  = state_q == CLEAR && !RESET;
        cnt_d   = clr_we ? cnt_q + 1'b1 : cnt_q;
        state_d = clr_we && cnt_q == LAST ? RUN : state_q;
        READY   = state_q == RUN;
    end

    always_comb begin
        act    = READY && !RESET;
        in0    = {1'b0, bus.A0} < DEPTH_L;
        in1    = {1'b0, bus.A1} < DEPTH_L;
        rd0    = act && !bus.CEN0 && bus.WEN0;
        rd1    = act && !bus.CEN1 && bus.WEN1;
        wr0    = act && !bus.CEN0 && !bus.WEN0 && in0;
        wr1    = act && !bus.CEN1 && !bus.WEN1 && in1;
        same   = act && !bus.CEN0 && !bus.CEN1 && bus.A0 == bus.A1;
        m0     = DATA_W'(lane_mask(MAX_NB'(bus.BWEN0)));
        m1     = DATA_W'(lane_mask(MAX_NB'(bus.BWEN1)));
        // Array read before this edge's writes land gives read-first collisions
        rdata0 = in0 ? mem[bus.A0] : '0;
        rdata1 = in1 ? mem[bus.A1] : '0;
        coll_d = (COLL_CLR ? 1'b0 : coll_q) | (same && (!bus.WEN0 || !bus.WEN1));
    end

    always_ff @(posedge CLK) begin
        if (RESET) begin
            state_q <= CLEAR;
            cnt_q   <= '0;
            coll_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            coll_q  <= coll_d;
        end
    end

    // Port 0 is assigned last so it wins any lane both ports enable on one address
    always_ff @(posedge CLK) begin
        if (clr_we) mem[cnt_q] <= '0;
        for (int i = 0; i < DATA_W; i++) begin
            if (wr1 && m1[i]) mem[bus.A1][i] <= bus.D1[i];
            if (wr0 && m0[i]) mem[bus.A0][i] <= bus.D0[i];
        end
    end

    assign COLL = coll_q;

    dpmem_port_rd #(.DATA_W(DATA_W)) u_rd0 (
        .clk       (CLK),
        .rst       (RESET),
        .rd_en_i   (rd0),
        .rd_data_i (rdata0),
        .q_o       (bus.Q0),
        .qv_o      (bus.QV0)
    );

    dpmem_port_rd #(.DATA_W(DATA_W)) u_rd1 (
        .clk       (CLK),
        .rst       (RESET),
        .rd_en_i   (rd1),
        .rd_data_i (rdata1),
        .q_o       (bus.Q1),
        .qv_o      (bus.QV1)
    );

endmodule

// File: doc/dpmem_bw_ctrl.md
Name: dpmem_bw_ctrl

Overview:
Parametrised true dual-port synchronous RAM with per-byte write masks, registered read data with valid strobes, and a hardware clear sequencer that zeroes the array after reset. It replaces fixed-size 2048x32 activation/weight memories. Both ports are symmetric and usable for any read/write mix. Deterministic rules cover same-address collisions, and a sticky collision flag is provided for debug.

Parameters:
DATA_W, 32, word width in bits; must be a multiple of 8
ADDR_W, 11, address width
DEPTH, 2048, number of words; must be ≤ 2**ADDR_W
NB, DATA_W/8, byte lanes (derived, not overridable)

Ports:
CLK  in  1  single clock; all logic on posedge
RESET  in  1  synchronous, active-high reset
CEN0  in  1  port 0 chip enable, active low
WEN0  in  1  port 0 write enable, active low (1 = read)
BWEN0  in  NB  port 0 byte write enables, active low; ignored on reads
A0  in  ADDR_W  port 0 address
D0  in  DATA_W  port 0 write data
Q0  out  DATA_W  port 0 read data, registered
QV0  out  1  port 0 read data valid, one-cycle pulse
CEN1, WEN1, BWEN1, A1, D1, Q1, QV1  same as port 0, for port 1
READY  out  1  high once the clear sweep is complete; requests are accepted only while high
COLL  out  1  sticky same-address collision flag
COLL_CLR  in  1  clears COLL (synchronous)

Behaviour:
- Reset (RESET=1 at posedge):
  - Q0=Q1=0, QV0=QV1=0, READY=0, COLL=0.
  - Sweep counter = 0; FSM state = CLEAR.
  - Reset asserted mid-sweep or mid-operation restarts the sweep from address 0.
- FSM state CLEAR:
  - Each cycle after reset deasserts, write 0 to mem[cnt] and increment cnt.
  - When cnt == DEPTH-1 is written, go to RUN the next cycle and set READY=1.
  - The sweep takes exactly DEPTH cycles.
  - All port requests are ignored: no writes, QV stays 0.
- FSM state RUN: READY=1. The state is left only via RESET.
- Read (CEN=0, WEN=1, READY=1, A<DEPTH):
  - Request at edge N gives Q = mem[A] and QV=1 after edge N (latency 1).
  - QV is 0 on cycles with no read.
  - Q holds its last value when no read occurs.
- Write (CEN=0, WEN=0, READY=1, A<DEPTH):
  - Lane b of mem[A] is updated from D[8b+7:8b] only where BWEN[b]=0.
  - Other lanes are unchanged. QV is not asserted.
- Out-of-range address (A ≥ DEPTH): writes are dropped; reads return 0 with QV=1.
- Read-during-write, same address, opposite ports, same edge: read-first. Q returns the contents before the edge; the new data is visible from the next read.
- Write-write, same address, same edge:
  - Per lane, port 0 wins where BWEN0[b]=0.
  - Lanes enabled only on port 1 take D1.
- COLL:
  - Set on any same-address cycle where both ports are enabled (CEN0=CEN1=0), READY=1, and at least one port writes.
  - Read-read on the same address does not set COLL.
  - COLL_CLR=1 clears it. If set and clear occur in the same cycle, set wins.
- Array contents are undefined only before the first completed sweep.

Optional Feature:
- Macro DPMEM_OUT_REG_EN.
- Defined: an extra output register stage on Q/QV for timing closure.
  - Read latency becomes 2; QV is delayed identically.
  - Reset clears both stages.
  - Back-to-back reads still give one result per cycle.
- Undefined: latency 1 as above.
- Collision, clear and READY behaviour are unchanged in both builds.

Decomposition:
- Package dpmem_pkg:
  - FSM state enum (CLEAR, RUN).
  - Default DATA_W/ADDR_W/DEPTH localparams.
  - A helper function that builds the byte-lane mask expansion (NB → DATA_W).
- Sub-module dpmem_port_rd: per-port read pipeline (Q/QV registers plus the optional second stage), instantiated twice.

Test Plan:
- Reset then idle → READY=0 for exactly 2048 cycles, then 1; reading addr 0x7FF returns 0x00000000, QV1 one cycle after request.
- Port 0 writes 0xDEADBEEF to 5, then port 1 reads 5 → Q1=0xDEADBEEF, QV1 pulses one cycle (two with DPMEM_OUT_REG_EN).
- mem[9]=0x11223344; port 0 writes 0xAABBCCDD with BWEN0=4'b1010 → read gives 0x11BB33DD.
- Same edge: port 0 writes 0x0000FFFF with BWEN0=4'b1100, port 1 writes 0x12345678 with BWEN1=4'b0000, both to 20 → mem[20]=0x1234FFFF; COLL=1 until COLL_CLR.
- Same edge: port 0 writes 0x55 to 7 (old 0x0), port 1 reads 7 → Q1=0x0; next read returns 0x55; COLL=1.
- RESET pulsed mid-sweep at count 100, and requests issued during CLEAR → sweep restarts at 0, no QV pulses, and no data is written by ports.
